// File: rtl/hazard_detection_unit.sv
// Issue-side hazard detection: scoreboards in-flight register writes and the mul/div unit, stalls ID.
// Optional macro FORWARDING_EN: when undefined, every writer stays pending FWD_GAP extra cycles.
module hazard_detection_unit #(
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int FWD_GAP  = 2,
    parameter int LAT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ID,
    input  logic [4:0]  src1_ID,
    input  logic [4:0]  src2_ID,
    input  logic        src2_used_ID,
    input  logic [4:0]  dest_ID,
    input  logic        WB_EN_ID,
    input  logic        MEM_R_EN_ID,
    input  logic        MD_EN_ID,
    input  logic        flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_count
);

`ifdef FORWARDING_EN
    localparam int GAP = 0;
`else
    localparam int GAP = FWD_GAP;
`endif

    localparam logic [LAT_W-1:0] L_ALU  = LAT_W'(ALU_LAT + GAP);
    localparam logic [LAT_W-1:0] L_LOAD = LAT_W'(LOAD_LAT + GAP);
    localparam logic [LAT_W-1:0] L_MD   = LAT_W'(MD_LAT + GAP);
    localparam logic [LAT_W-1:0] MD_OCC = LAT_W'(MD_LAT);

    // A younger write must never shorten an older pending window.
    function automatic logic [LAT_W-1:0] lat_max(input logic [LAT_W-1:0] a,
                                                 input logic [LAT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [31:0]      pend;
    logic [LAT_W-1:0] cnt [1:31];
    logic [LAT_W-1:0] md_cnt;

    logic             raw1;
    logic             raw2;
    logic             md_hazard;
    logic             issue;
    logic [LAT_W-1:0] lat;

    always_comb begin
        raw1      = (src1_ID != 5'd0) && pend[src1_ID];
        raw2      = src2_used_ID && (src2_ID != 5'd0) && pend[src2_ID];
        md_hazard = MD_EN_ID && (md_cnt != '0);
        stall     = valid_ID && !flush && (raw1 || raw2 || md_hazard);
        issue     = valid_ID && !flush && !stall;
        if (MEM_R_EN_ID)
            lat = L_LOAD;
        else if (MD_EN_ID)
            lat = L_MD;
        else
            lat = L_ALU;
    end

    assign md_busy = (md_cnt != '0);

    // Scoreboard, mul/div occupancy and stall statistics; pend[0] is never set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            md_cnt      <= '0;
            stall_count <= '0;
            for (int r = 1; r < 32; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue && WB_EN_ID && (dest_ID == 5'(r)) && (lat != '0)) begin
                    cnt[r]  <= lat_max(cnt[r] - LAT_W'(pend[r]), lat);
                    pend[r] <= 1'b1;
                end else if (pend[r]) begin
                    cnt[r]  <= cnt[r] - LAT_W'(1);
                    pend[r] <= (cnt[r] != LAT_W'(1));
                end
            end

            if (issue && MD_EN_ID)
                md_cnt <= MD_OCC;
            else if (md_cnt != '0)
                md_cnt <= md_cnt - LAT_W'(1);

            if (stall)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule
